// File: rtl/vend_pkg.sv
// Shared types and constants for the vend dispense controller.
package vend_pkg;

  localparam int CHANGE_W_DFLT = 3;
  localparam int UNIT          = 5;  // cents per change unit
  localparam int NICKEL_UNITS  = 1;
  localparam int DIME_UNITS    = 2;

  typedef logic [CHANGE_W_DFLT-1:0] change_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SODA   = 2'd1,
    CHANGE = 2'd2,
    FAULT  = 2'd3
  } state_e;

endpackage

// File: rtl/vend_event_fifo.sv
// Synchronous FIFO holding pending vend change amounts; pointers wrap modulo DEPTH.
module vend_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: buffers vend events and drives soda/coin actuator handshakes.
// Optional ack watchdog enabled by defining VEND_DISPENSE_ACK_TIMEOUT_EN.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CHANGE_W   = CHANGE_W_DFLT
`ifdef VEND_DISPENSE_ACK_TIMEOUT_EN
  ,
  parameter int ACK_TIMEOUT = 16
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_vend,
  input  logic [CHANGE_W-1:0] i_change,
  output logic                o_soda_req,
  input  logic                i_soda_ack,
  output logic                o_coin_req,
  output logic                o_coin_dime,
  input  logic                i_coin_ack,
  output logic                o_busy,
  output logic                o_full,
  output logic                o_overflow,
  output logic                o_fault
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e              state_q, state_d;
  logic [CHANGE_W-1:0] rem_q, rem_d;
  logic [CHANGE_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]    fifo_count, count_nx;
  logic                fifo_full, fifo_empty;
  logic                push, pop, drop;
  logic                soda_ack_acc, coin_ack_acc, tmo_fire;
  logic                soda_req_q, soda_req_d;
  logic                coin_req_q, coin_req_d;
  logic                coin_dime_q, coin_dime_d;
  logic                busy_q, busy_d;
  logic                full_q, full_d;
  logic                overflow_q, overflow_d;

  assign pop  = (state_q == IDLE) && !fifo_empty;
  assign push = i_vend && (!fifo_full || pop);
  assign drop = i_vend && fifo_full && !pop;

  // Acks only count while the matching request is actually presented.
  assign soda_ack_acc = soda_req_q && i_soda_ack;
  assign coin_ack_acc = coin_req_q && i_coin_ack;

  vend_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CHANGE_W)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (i_change),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    count_nx = fifo_count;
    if (push && !pop)      count_nx = fifo_count + CNT_W'(1);
    else if (pop && !push) count_nx = fifo_count - CNT_W'(1);
  end

`ifdef VEND_DISPENSE_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             req_wait;

  // Any accepted ack or idle request cycle restarts the count for the next request.
  assign req_wait = (soda_req_q && !soda_ack_acc) || (coin_req_q && !coin_ack_acc);
  assign tmo_d    = req_wait ? tmo_q + TMO_W'(1) : '0;
  assign tmo_fire = req_wait && (tmo_q == TMO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Dimes first: each coin takes two units while at least two remain.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = SODA;
          rem_d   = fifo_rdata;
        end
      end
      SODA: begin
        if (soda_ack_acc) state_d = (rem_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (coin_ack_acc) begin
          rem_d = (rem_q >= CHANGE_W'(DIME_UNITS)) ? rem_q - CHANGE_W'(DIME_UNITS)
                                                   : rem_q - CHANGE_W'(NICKEL_UNITS);
          if (rem_d == '0) state_d = IDLE;
        end
      end
      default: state_d = state_q;
    endcase
    if (tmo_fire) state_d = FAULT;
  end

  // Outputs are registered from next-state values so they line up with the state register.
  always_comb begin
    soda_req_d  = (state_d == SODA);
    coin_req_d  = (state_d == CHANGE) && !coin_ack_acc;
    coin_dime_d = coin_req_d && (rem_d >= CHANGE_W'(DIME_UNITS));
    busy_d      = (state_d != IDLE) || (count_nx != '0);
    full_d      = (count_nx == CNT_W'(FIFO_DEPTH));
    overflow_d  = overflow_q || drop;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      soda_req_q  <= 1'b0;
      coin_req_q  <= 1'b0;
      coin_dime_q <= 1'b0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      soda_req_q  <= soda_req_d;
      coin_req_q  <= coin_req_d;
      coin_dime_q <= coin_dime_d;
      busy_q      <= busy_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef VEND_DISPENSE_ACK_TIMEOUT_EN
  logic fault_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) fault_q <= 1'b0;
    else          fault_q <= (state_d == FAULT);
  end

  assign o_fault = fault_q;
`else
  assign o_fault = 1'b0;
`endif

  assign o_soda_req  = soda_req_q;
  assign o_coin_req  = coin_req_q;
  assign o_coin_dime = coin_dime_q;
  assign o_busy      = busy_q;
  assign o_full      = full_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: event-level model compared every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_vend_dispense_ctrl;

  localparam int DEPTH       = 4;
  localparam int CW          = 3;
  localparam int ACK_TIMEOUT = 16;

  logic          i_clk      = 1'b0;
  logic          i_rst_n    = 1'b0;
  logic          i_vend     = 1'b0;
  logic [CW-1:0] i_change   = '0;
  logic          i_soda_ack = 1'b0;
  logic          i_coin_ack = 1'b0;
  logic          o_soda_req, o_coin_req, o_coin_dime, o_busy, o_full, o_overflow, o_fault;

  vend_dispense_ctrl #(.FIFO_DEPTH(DEPTH), .CHANGE_W(CW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_vend      (i_vend),
    .i_change    (i_change),
    .o_soda_req  (o_soda_req),
    .i_soda_ack  (i_soda_ack),
    .o_coin_req  (o_coin_req),
    .o_coin_dime (o_coin_dime),
    .i_coin_ack  (i_coin_ack),
    .o_busy      (o_busy),
    .o_full      (o_full),
    .o_overflow  (o_overflow),
    .o_fault     (o_fault)
  );

  always #5 i_clk = ~i_clk;

  int ncmp = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input int got, input int exp);
    ncmp++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Actuator responders: ack after a programmable number of request cycles (-1 = never).
  int soda_dly = 0;
  int coin_dly = 0;
  bit coin_stuck = 1'b0;
  int scnt = 0;
  int ccnt = 0;

  always @(posedge i_clk) begin
    #1;
    scnt = o_soda_req ? scnt + 1 : 0;
    ccnt = o_coin_req ? ccnt + 1 : 0;
    i_soda_ack = (soda_dly >= 0) && o_soda_req && (scnt > soda_dly);
    i_coin_ack = coin_stuck || ((coin_dly >= 0) && o_coin_req && (ccnt > coin_dly));
  end

  // Event-level model: pending queue plus the action list of the event being dispensed
  // (0 = soda, 2 = dime, 1 = nickel).
  int q[$];
  int acts[$];
  bit req_on, m_ovf, m_flt;
  int tmo;

  always @(posedge i_clk or negedge i_rst_n) begin : model
    bit pop_m, ack_m;
    int c, head;
    if (!i_rst_n) begin
      q.delete();
      acts.delete();
      req_on = 1'b0;
      m_ovf  = 1'b0;
      m_flt  = 1'b0;
      tmo    = 0;
    end else begin
      pop_m = !m_flt && (acts.size() == 0) && (q.size() != 0);
      ack_m = 1'b0;
      if (req_on) ack_m = (acts[0] == 0) ? i_soda_ack : i_coin_ack;
      if (pop_m) begin
        c = q.pop_front();
        acts.push_back(0);
        for (int i = 0; i < c / 2; i++) acts.push_back(2);
        if (c % 2 == 1) acts.push_back(1);
        req_on = 1'b1;
        tmo    = 0;
      end else if (req_on && ack_m) begin
        head   = acts.pop_front();
        req_on = (head == 0) && (acts.size() != 0);
        tmo    = 0;
      end else if (req_on) begin
`ifdef VEND_DISPENSE_ACK_TIMEOUT_EN
        if (tmo == ACK_TIMEOUT - 1) begin
          m_flt  = 1'b1;
          req_on = 1'b0;
          acts.delete();
        end else tmo++;
`else
        tmo++;
`endif
      end else if (acts.size() != 0) begin
        req_on = 1'b1;
        tmo    = 0;
      end
      if (i_vend) begin
        if (q.size() < DEPTH) q.push_back(int'(i_change));
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n && chk_en) begin : compare
      int hd;
      hd = (acts.size() != 0) ? acts[0] : -1;
      cmp("soda_req",  int'(o_soda_req),  int'(req_on && hd == 0));
      cmp("coin_req",  int'(o_coin_req),  int'(req_on && hd > 0));
      cmp("coin_dime", int'(o_coin_dime), int'(req_on && hd == 2));
      cmp("busy",      int'(o_busy),      int'(acts.size() != 0 || q.size() != 0 || m_flt));
      cmp("full",      int'(o_full),      int'(q.size() == DEPTH));
      cmp("overflow",  int'(o_overflow),  int'(m_ovf));
      cmp("fault",     int'(o_fault),     int'(m_flt));
    end
  end

  // Record what the actuators actually completed.
  int coins_seen[$];
  int sodas = 0;

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_coin_req && i_coin_ack) coins_seen.push_back(o_coin_dime ? 2 : 1);
      if (o_soda_req && i_soda_ack) sodas++;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int k = 0; k < max_cyc && o_busy; k++) tick();
    cmp("idle_wait", int'(o_busy), 0);
  endtask

  task automatic chk_coins(input string nm, input int exp_q[$]);
    cmp({nm, "_count"}, coins_seen.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < coins_seen.size(); i++)
      cmp($sformatf("%s_%0d", nm, i), coins_seen[i], exp_q[i]);
  endtask

  task automatic vend(input int chg);
    i_vend   = 1'b1;
    i_change = CW'(chg);
    tick();
    i_vend   = 1'b0;
  endtask

  initial begin : stim
    int tbl[5];
    tbl = '{1, 2, 3, 0, 7};

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk_en  = 1'b1;
    #1;
    cmp("rst_soda_req", int'(o_soda_req), 0);
    cmp("rst_coin_req", int'(o_coin_req), 0);
    cmp("rst_busy",     int'(o_busy),     0);
    cmp("rst_full",     int'(o_full),     0);
    cmp("rst_overflow", int'(o_overflow), 0);

    // Single vend with no change, immediate acks.
    tick();
    vend(0);
    cmp("lat_n1_soda", int'(o_soda_req), 0);
    cmp("lat_n1_busy", int'(o_busy),     1);
    tick();
    cmp("lat_n2_soda", int'(o_soda_req), 1);
    tick();
    cmp("after_ack_soda", int'(o_soda_req), 0);
    cmp("after_ack_busy", int'(o_busy),     0);
    cmp("no_coin_req",    int'(o_coin_req), 0);

    // Change 5: dime, dime, nickel with slow coin acks.
    coins_seen.delete();
    coin_dly = 3;
    vend(5);
    wait_idle(200);
    chk_coins("chg5", '{2, 2, 1});

    // Back-to-back vends fill the FIFO, then one is dropped.
    coins_seen.delete();
    sodas    = 0;
    soda_dly = 10;
    coin_dly = 10;
    foreach (tbl[i]) begin
      i_vend   = 1'b1;
      i_change = CW'(tbl[i]);
      tick();
    end
    cmp("fill_full",     int'(o_full),     1);
    cmp("fill_overflow", int'(o_overflow), 0);
    i_change = CW'(6);
    tick();
    i_vend = 1'b0;
    cmp("drop_overflow", int'(o_overflow), 1);
    cmp("drop_full",     int'(o_full),     1);
    wait_idle(2000);
    cmp("burst_sodas", sodas, 5);
    chk_coins("burst", '{1, 2, 2, 1, 2, 2, 2, 1});
    cmp("overflow_sticky", int'(o_overflow), 1);

    // Stuck-high coin ack still yields one coin per request.
    coins_seen.delete();
    soda_dly   = 0;
    coin_stuck = 1'b1;
    vend(3);
    wait_idle(100);
    chk_coins("stuck", '{2, 1});
    coin_stuck = 1'b0;
    tick();

    // Reset in the middle of a coin handshake.
    coin_dly = -1;
    vend(2);
    for (int k = 0; k < 20 && !o_coin_req; k++) tick();
    cmp("mid_coin_req", int'(o_coin_req), 1);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    cmp("arst_soda_req",  int'(o_soda_req),  0);
    cmp("arst_coin_req",  int'(o_coin_req),  0);
    cmp("arst_coin_dime", int'(o_coin_dime), 0);
    cmp("arst_busy",      int'(o_busy),      0);
    cmp("arst_full",      int'(o_full),      0);
    cmp("arst_overflow",  int'(o_overflow),  0);
    cmp("arst_fault",     int'(o_fault),     0);
    coin_dly = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) tick();
    cmp("post_rst_busy",     int'(o_busy),     0);
    cmp("post_rst_coin_req", int'(o_coin_req), 0);

    // Soda actuator never acks.
    soda_dly = -1;
    vend(1);
    for (int k = 0; k < 20 && !o_soda_req; k++) tick();
    cmp("hang_req_seen", int'(o_soda_req), 1);
`ifdef VEND_DISPENSE_ACK_TIMEOUT_EN
    repeat (ACK_TIMEOUT - 1) tick();
    cmp("tmo_pre_fault", int'(o_fault),    0);
    cmp("tmo_pre_req",   int'(o_soda_req), 1);
    tick();
    cmp("tmo_fault",     int'(o_fault),    1);
    cmp("tmo_req_drop",  int'(o_soda_req), 0);
    cmp("tmo_busy",      int'(o_busy),     1);
    repeat (5) tick();
    cmp("tmo_fault_hold", int'(o_fault),   1);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    cmp("tmo_rst_fault", int'(o_fault), 0);
    soda_dly = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) tick();
`else
    repeat (110) tick();
    cmp("hold_req",   int'(o_soda_req), 1);
    cmp("hold_fault", int'(o_fault),    0);
    soda_dly = 0;
    wait_idle(50);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", ncmp);
    $fatal(1, "bench watchdog expired");
  end

endmodule
